mul128_sched: RTL and testbench
===============================

Name: mul128_sched

Overview:
- Round-robin scheduler that shares one pipelined 128x128 multiplier (2W-bit product, fixed latency MUL_LAT, no stall) between NREQ operand requesters.
- Issues at most one product per cycle. Tracks each in-flight product's owner through a tag shift pipe and returns the result with the owner id.
- Limits outstanding products per requester with credit counters.
- Sits between the IDDMM word-loop controllers and the shared multiplier instance.

Parameters:
- W, 128, operand width; product is 2*W.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester id width, equal to clog2(NREQ).
- MUL_LAT, 4, multiplier latency in cycles from mul_a/mul_b to mul_s (at least 1).
- MAX_OUT, 3, maximum in-flight products per requester (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*W  operand a; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  operand b; same packing as req_a.
- mul_a  out  W  registered operand a to the multiplier.
- mul_b  out  W  registered operand b to the multiplier.
- mul_s  in  2*W  multiplier product.
- res_valid  out  1  result strobe; lasts one cycle; no backpressure.
- res_id  out  IDW  owner of res_data.
- res_data  out  2*W  registered product.
- busy  out  1  high while any product is in flight.

Behaviour:
- Reset values: req_ready=0 (combinational, forced low during rst); mul_a=0; mul_b=0; res_valid=0; res_id=0; res_data=0; busy=0; rr pointer=NREQ-1, so requester 0 has first priority; all credit counters=0; tag pipe cleared.
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i] < MAX_OUT.
- Arbitration: among eligible requesters, pick the first at or after (ptr+1) mod NREQ. req_ready is that one-hot grant, computed combinationally. ready may depend on valid.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] at an edge.
  - On transfer: ptr<=i; mul_a/mul_b<=requester i operands; tag pipe stage0<={1,i}.
  - With no transfer: mul_a/mul_b hold their values; stage0 valid<=0.
- Tag pipe: MUL_LAT stages that shift every cycle and never stall.
- Latency: transfer at edge t; mul_a valid after edge t; mul_s sampled at edge t+MUL_LAT; res_* update at that edge. res_valid is high for one cycle.
  - Result visible MUL_LAT cycles after the transfer edge.
  - Back-to-back transfers give back-to-back results in issue order.
- Credits:
  - Increment credit[i] on transfer by i.
  - Decrement credit[j] when a result for j exits the tag pipe.
  - Increment and decrement for the same requester in the same cycle: counter unchanged.
  - A requester at MAX_OUT is skipped without blocking others, and becomes eligible again in the cycle its result retires.
- busy: registered; high when any tag stage is valid or any credit is nonzero.
- Operands must be held stable by the requester until granted. Dropping valid before grant is allowed; nothing is issued for it.
- Reset mid-operation: in-flight products are discarded (no res_valid for them); credits and pointer return to reset values.
- res_data is updated only when res_valid is asserted; otherwise it holds its value.

Optional Feature:
- MUL128_SCHED_STATS_EN defined:
  - Extra outputs stat_issued (32 bits): count of transfers.
  - stat_stall (32 bits): cycles with any req_valid high but no grant because of credit limits.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: W_DEFAULT=128, product width 2*W, id width as clog2(NREQ), and the tag struct {valid, id}.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin one-hot grant from a request mask and last-grant pointer).
- Tag pipe and credit counters stay in the top.

Test Plan:
- Single request: req 0 a=3, b=5 held valid.
  - Granted in cycle 0; res_valid one cycle after MUL_LAT edges.
  - res_id=0, res_data=15; busy drops the cycle after.
- Fairness: all 4 requesters continuously valid with MAX_OUT=3.
  - Grant order 0,1,2,3,0,... with one grant per cycle.
  - Results return in the same order with matching ids.
- Credit limit: only req 2 valid with MUL_LAT=4, MAX_OUT=3.
  - Three grants, then ready low for 1 cycle until the first result retires.
  - Steady pattern: 3 issued per 4 cycles.
- Boundary operands: a=b=2^128-1.
  - res_data = 2^256 - 2^129 + 1.
  - a=0, b=max gives res_data=0.
- Reset mid-flight: assert rst with 3 products outstanding.
  - No res_valid follows; credits=0; the next grant goes to req 0.
- Simultaneous retire and issue for the same requester at MAX_OUT:
  - Credit stays at MAX_OUT with no overflow.
  - With STATS_EN, stat_stall counts only the blocked cycles.

Source files
------------

// File: rtl/mul128_sched_pkg.sv
// Shared types and sizing helpers for the mul128_sched multiplier scheduler.
// Tag width is fixed at the 16-requester maximum so the tag struct stays parameter-free.
package mul128_sched_pkg;

  localparam int W_DEFAULT = 128;
  localparam int TAG_IDW   = 4;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul128_sched_if.sv
// Requester, multiplier and result bundle for mul128_sched.
// master = requesters plus multiplier model, slave = the scheduler.
interface mul128_sched_if
  import mul128_sched_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic [prod_w(W)-1:0] mul_s;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [prod_w(W)-1:0] res_data;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, mul_s,
    input  req_ready, mul_a, mul_b, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_s,
    output req_ready, mul_a, mul_b, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/mul128_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: searches from (ptr+1) mod NREQ for the first set request.
module mul128_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul128_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NREQ requesters.
// Optional MUL128_SCHED_STATS_EN adds saturating stat_issued / stat_stall counters.
module mul128_sched
  import mul128_sched_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int NREQ    = 4,
  parameter int IDW     = id_w(NREQ),
  parameter int MUL_LAT = 4,
  parameter int MAX_OUT = 3
) (
  input  logic          clk,
  input  logic          rst,
  mul128_sched_if.slave bus
`ifdef MUL128_SCHED_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_stall
`endif
);

  localparam int CW = 4;

  tag_t            tag_p [MUL_LAT];
  logic [CW-1:0]   credit [NREQ];
  logic [CW-1:0]   credit_nxt [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] retire;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] issue;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr;
  logic            grant_any;
  logic            xfer;
  logic            ret_vld;
  logic            busy_nxt;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  assign ret_vld = tag_p[MUL_LAT-1].valid;

  // A requester at its credit limit is eligible again in the cycle its oldest result retires.
  always_comb begin
    eligible = '0;
    retire   = '0;
    for (int i = 0; i < NREQ; i++) begin
      retire[i]   = ret_vld && (tag_p[MUL_LAT-1].id == TAG_IDW'(i));
      eligible[i] = bus.req_valid[i] && ((credit[i] < CW'(MAX_OUT)) || retire[i]);
    end
  end

  mul128_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign bus.req_ready = rst ? '0 : grant;
  assign issue         = bus.req_valid & bus.req_ready;
  assign xfer          = |issue;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    busy_nxt = xfer;
    for (int k = 0; k < MUL_LAT; k++) begin
      busy_nxt = busy_nxt | tag_p[k].valid;
    end
    for (int i = 0; i < NREQ; i++) begin
      credit_nxt[i] = credit[i];
      if (issue[i] && !retire[i]) begin
        credit_nxt[i] = credit[i] + CW'(1);
      end else if (!issue[i] && retire[i]) begin
        credit_nxt[i] = credit[i] - CW'(1);
      end
      busy_nxt = busy_nxt | (credit_nxt[i] != '0);
    end
  end

  // Stage p0: operand register and tag entry; tags shift MUL_LAT stages to the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= IDW'(NREQ - 1);
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_data  <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_p[k] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        credit[i] <= '0;
      end
    end else begin
      if (xfer) begin
        ptr       <= grant_id;
        bus.mul_a <= sel_a;
        bus.mul_b <= sel_b;
      end
      tag_p[0] <= '{valid: xfer, id: TAG_IDW'(grant_id)};
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_p[k] <= tag_p[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        credit[i] <= credit_nxt[i];
      end
      bus.busy      <= busy_nxt;
      bus.res_valid <= ret_vld;
      if (ret_vld) begin
        bus.res_id   <= tag_p[MUL_LAT-1].id[IDW-1:0];
        bus.res_data <= bus.mul_s;
      end
    end
  end

`ifdef MUL128_SCHED_STATS_EN
  // Stall means someone is asking but every asker is held off by its credit limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (xfer && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if ((|bus.req_valid) && !grant_any && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul128_sched.sv
// Scoreboard bench for mul128_sched: directed operand jobs, hand-computed products and grant order.
module tb_mul128_sched;
  import mul128_sched_pkg::*;

  localparam int W       = 128;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 4;
  localparam int MAX_OUT = 3;
  localparam int PW      = 2 * W;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  typedef struct {
    int          id;
    logic [PW-1:0] p;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul128_sched_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef MUL128_SCHED_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  mul128_sched #(
    .W       (W),
    .NREQ    (NREQ),
    .IDW     (IDW),
    .MUL_LAT (MUL_LAT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MUL128_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  // Multiplier model: product of the operands registered at edge t is on mul_s before edge t+MUL_LAT.
  logic [PW-1:0] mp [MUL_LAT-1];
  always @(posedge clk) begin
    mp[0] <= {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};
    for (int k = 1; k < MUL_LAT - 1; k++) mp[k] <= mp[k-1];
  end
  assign bus.mul_s = mp[MUL_LAT-2];

  job_t jobs [NREQ][$];
  exp_t exp_g [$];
  exp_t res_q [$];
  int   gcyc [$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  localparam logic [W-1:0] MAXW = {W{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #3;
  endtask

  task automatic add_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    job_t j;
    j.a = a;
    j.b = b;
    jobs[i].push_back(j);
  endtask

  task automatic expect_res(input int i, input logic [PW-1:0] p);
    exp_t e;
    e.id  = i;
    e.p   = p;
    e.cyc = 0;
    exp_g.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      if (jobs[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*W +: W]    = jobs[i][0].a;
        bus.req_b[i*W +: W]    = jobs[i][0].b;
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  // Requester driver: operands stay put until the grant seen before an edge has been taken.
  logic [NREQ-1:0] g_drv;
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    forever begin
      @(negedge clk);
      g_drv = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g_drv[i] && (jobs[i].size() > 0)) void'(jobs[i].pop_front());
      end
      apply();
    end
  end

  // Monitor: grants move expectations into the result queue; results are popped and compared.
  logic [NREQ-1:0] mg;
  int              mgid;
  exp_t            me;
  always @(negedge clk) begin
    if (!rst) begin
      mg = bus.req_valid & bus.req_ready;
      if (mg != '0) begin
        chk("grant_onehot", $countones(mg), 1);
        mgid = 0;
        for (int i = 0; i < NREQ; i++) if (mg[i]) mgid = i;
        if (exp_g.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got requester %0d required none", mgid);
        end else begin
          me = exp_g.pop_front();
          chk("grant_id", mgid, me.id);
          me.cyc = cyc;
          res_q.push_back(me);
          gcyc.push_back(cyc);
        end
      end
      if (bus.res_valid) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got id %0d data %h required none", bus.res_id, bus.res_data);
        end else begin
          me = res_q.pop_front();
          chk("res_id", bus.res_id, me.id);
          chk("res_data", bus.res_data, me.p);
          chk("res_latency", cyc - me.cyc, MUL_LAT + 1);
        end
      end
    end
  end

  task automatic reset_checks();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) jobs[i].delete();
    exp_g.delete();
    res_q.delete();
    gcyc.delete();
    repeat (2) @(negedge clk);
    reset_checks();
    sync();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k;
    k = 0;
    while (((exp_g.size() != 0) || (res_q.size() != 0)) && (k < maxc)) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if ((exp_g.size() != 0) || (res_q.size() != 0)) begin
      fails++;
      $display("FAIL %s_drain: got %0d grants and %0d results pending required 0", name, exp_g.size(), res_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  int cgap [5] = '{1, 1, 2, 1, 1};
  int nres;
  int k;

  initial begin
    // Reset with requester 0 already asking: ready must stay low until release.
    repeat (2) @(negedge clk);
    add_job(0, 128'd3, 128'd5);
    repeat (2) @(negedge clk);
    chk("rst_valid_pending_ready", bus.req_ready, 0);
    reset_checks();
    expect_res(0, 256'd15);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("single_first_grant", bus.req_ready, 4'b0001);
    k = 0;
    while (!bus.res_valid && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    chk("single_res_seen", bus.res_valid, 1);
    chk("single_busy_at_res", bus.busy, 1);
    @(negedge clk);
    chk("single_res_strobe", bus.res_valid, 0);
    chk("single_busy_after", bus.busy, 0);
    wait_drain("single", 20);

    // Fairness: everybody asking, one grant per cycle in rotation.
    do_reset();
    add_job(0, 128'd2, 128'd3);         add_job(0, 128'd4, 128'd5);
    add_job(1, 128'd7, 128'd11);        add_job(1, 128'd13, 128'd17);
    add_job(2, 128'd100, 128'd200);     add_job(2, 128'h10000, 128'h10000);
    add_job(3, MAXW, 128'd2);           add_job(3, 128'd12345, 128'd1000);
    expect_res(0, 256'd6);
    expect_res(1, 256'd77);
    expect_res(2, 256'd20000);
    expect_res(3, {128'h1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    expect_res(0, 256'd20);
    expect_res(1, 256'd221);
    expect_res(2, 256'h1_0000_0000);
    expect_res(3, 256'd12345000);
    wait_drain("fair", 60);
    chk("fair_ngrant", gcyc.size(), 8);
    for (int i = 1; i < gcyc.size(); i++) chk("fair_gap", gcyc[i] - gcyc[i-1], 1);

    // Credit limit: lone requester 2 gets 3 grants per 4 cycles.
    do_reset();
    for (int i = 1; i <= 6; i++) add_job(2, W'(i), 128'd3);
    expect_res(2, 256'd3);
    expect_res(2, 256'd6);
    expect_res(2, 256'd9);
    expect_res(2, 256'd12);
    expect_res(2, 256'd15);
    expect_res(2, 256'd18);
    wait_drain("credit", 60);
    chk("credit_ngrant", gcyc.size(), 6);
    for (int i = 1; i < gcyc.size() && i <= 5; i++) chk("credit_gap", gcyc[i] - gcyc[i-1], cgap[i-1]);
    chk("credit_busy_idle", bus.busy, 0);
`ifdef MUL128_SCHED_STATS_EN
    chk("stat_issued", stat_issued, 6);
    chk("stat_stall", stat_stall, 1);
`endif

    // Boundary operands, mixed with a second requester.
    do_reset();
    add_job(3, MAXW, MAXW);
    add_job(3, 128'd0, MAXW);
    add_job(3, MAXW, 128'd2);
    add_job(1, 128'd7, 128'd11);
    expect_res(1, 256'd77);
    expect_res(3, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1});
    expect_res(3, 256'd0);
    expect_res(3, {128'h1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    wait_drain("boundary", 40);

    // Reset with three products in flight: nothing comes back, priority restarts at 0.
    do_reset();
    add_job(1, 128'd2, 128'd2);
    add_job(1, 128'd3, 128'd3);
    add_job(1, 128'd4, 128'd4);
    expect_res(1, 256'd4);
    expect_res(1, 256'd9);
    expect_res(1, 256'd16);
    k = 0;
    while ((gcyc.size() < 3) && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    chk("flight_ngrant", gcyc.size(), 3);
    chk("flight_busy", bus.busy, 1);
    do_reset();
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid) nres++;
    end
    chk("flush_no_res", nres, 0);
    chk("flush_busy", bus.busy, 0);
    sync();
    add_job(0, 128'd5, 128'd6);
    add_job(1, 128'd8, 128'd9);
    add_job(3, 128'd10, 128'd10);
    expect_res(0, 256'd30);
    expect_res(1, 256'd72);
    expect_res(3, 256'd100);
    wait_drain("after_flush", 40);

    chk("queues_empty", exp_g.size() + res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
